// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared opcode constants and FSM state type for the M-extension unit
package muldiv_unit_pkg;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
// acc_i holds {hi, lo}: product/multiplier for multiply, remainder/quotient for divide.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              div_i,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   b_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0] add_d;
   logic [XLEN:0] diff_d;

   always_comb begin
      add_d  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, b_i} : {(XLEN+1){1'b0}});
      // Trial subtract on the partial remainder after its left shift.
      diff_d = acc_i[2*XLEN-1:XLEN-1] - {1'b0, b_i};
      if (div_i) begin
         if (diff_d[XLEN])
            acc_o = {acc_i[2*XLEN-2:0], 1'b0};
         else
            acc_o = {diff_d[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
         acc_o = {add_d, acc_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with START/BUSY/DONE handshake and flush
// FAST_MUL_EN: when defined, multiplies bypass CALC through a single-cycle multiplier.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [2:0]      func3_i,
   input  logic [XLEN-1:0] operand1_i,
   input  logic [XLEN-1:0] operand2_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int W2 = 2 * XLEN;
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        func3_q;
   logic              neg_q;
   logic [W2-1:0]     acc_q;
   logic [XLEN-1:0]   b_q;
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   logic              sgn1_en, sgn2_en, sgn1, sgn2;
   logic [XLEN-1:0]   mag1, mag2, spec_val;
   logic              div_op, rem_op, div_zero, div_ovf;
   logic              neg_d, direct_d, direct_neg_d;
   logic [W2-1:0]     direct_acc_d, step_d, full_d;
   logic [XLEN-1:0]   half_d, result_d;
   logic              lo_sel;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .div_i (func3_q[2]),
      .acc_i (acc_q),
      .b_i   (b_q),
      .acc_o (step_d)
   );

   always_comb begin
      sgn1_en = 1'b0;
      sgn2_en = 1'b0;
      case (func3_i)
         MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
            sgn1_en = 1'b1;
            sgn2_en = 1'b1;
         end
         MD_MULHSU: sgn1_en = 1'b1;
         MD_MULHU, MD_DIVU, MD_REMU: begin
            sgn1_en = 1'b0;
         end
         default: sgn1_en = 1'b0;
      endcase
      sgn1     = sgn1_en & operand1_i[XLEN-1];
      sgn2     = sgn2_en & operand2_i[XLEN-1];
      mag1     = sgn1 ? -operand1_i : operand1_i;
      mag2     = sgn2 ? -operand2_i : operand2_i;
      div_op   = func3_i[2];
      rem_op   = func3_i[1];
      div_zero = div_op && (operand2_i == '0);
      div_ovf  = sgn1_en && div_op && (operand1_i == {1'b1, {(XLEN-1){1'b0}}})
                 && (operand2_i == '1);
      // Remainder takes the dividend's sign; everything else takes sign1 ^ sign2.
      neg_d    = (div_op && rem_op) ? sgn1 : (sgn1 ^ sgn2);
      if (div_zero)
         spec_val = rem_op ? operand1_i : '1;
      else
         spec_val = rem_op ? '0 : operand1_i;
      direct_d     = div_zero | div_ovf;
      direct_acc_d = {spec_val, spec_val};
      direct_neg_d = 1'b0;
`ifdef FAST_MUL_EN
      if (!div_op) begin
         direct_d     = 1'b1;
         direct_acc_d = W2'(mag1) * W2'(mag2);
         direct_neg_d = neg_d;
      end
`endif
   end

   always_comb begin
      full_d = neg_q ? -acc_q : acc_q;
      lo_sel = (func3_q == MD_MUL) || (func3_q == MD_DIV) || (func3_q == MD_DIVU);
      half_d = lo_sel ? acc_q[XLEN-1:0] : acc_q[W2-1:XLEN];
      if (func3_q[2])
         result_d = neg_q ? -half_d : half_d;
      else
         result_d = lo_sel ? full_d[XLEN-1:0] : full_d[W2-1:XLEN];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         func3_q  <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         b_q      <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i && !flush_i) begin
                  func3_q <= func3_i;
                  cnt_q   <= '0;
                  if (direct_d) begin
                     acc_q   <= direct_acc_d;
                     neg_q   <= direct_neg_d;
                     state_q <= ST_FIN;
                  end else begin
                     // Multiply iterates over the multiplier; divide shifts in the dividend.
                     acc_q   <= {{XLEN{1'b0}}, div_op ? mag1 : mag2};
                     b_q     <= div_op ? mag2 : mag1;
                     neg_q   <= neg_d;
                     state_q <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (flush_i) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else begin
                  acc_q <= step_d;
                  if (cnt_q == CNT_LAST) begin
                     cnt_q   <= '0;
                     state_q <= ST_FIN;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
               if (!flush_i) begin
                  result_q <= result_d;
                  done_q   <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o   = (state_q != ST_IDLE);
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  func3;
   logic [31:0] op1, op2;
   logic        busy, done;
   logic [31:0] result;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_last = '0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .start_i    (start),
      .func3_i    (func3),
      .operand1_i (op1),
      .operand2_i (op2),
      .flush_i    (flush),
      .busy_o     (busy),
      .done_o     (done),
      .result_o   (result)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      p  = '0;
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
      if (!f3[2]) return 1;
`endif
      return 33;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Caller must be at a falling edge; returns at a falling edge.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input bit poke);
      int lat, busy_cnt, exp_lat;
      exp_lat = exp_latency(f3, a, b);
      start = 1'b1; func3 = f3; op1 = a; op2 = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0; busy_cnt = 0;
      while (!done && lat < 100) begin
         if (busy) busy_cnt++;
         start = poke && (lat == 3);
         if (start) begin
            func3 = 3'($urandom_range(0, 7)); op1 = $urandom; op2 = $urandom;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({tag, " done"}, 64'(done), 64'(1));
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
      check({tag, " result"}, 64'(result), 64'(exp_res));
      exp_last = exp_res;
      @(negedge clk);
      check({tag, " done pulse"}, 64'(done), 64'(0));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; op1 = '0; op2 = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset result", 64'(result), 64'(0));
      reset = 1'b0;
      @(negedge clk);

      run_op("MUL 7*-3",   3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      run_op("MULH -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      run_op("MULHSU",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("MULHU",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op("DIV -7/2",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      run_op("REM -7/2",   3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
      run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
      run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
      run_op("DIVU 5/0",   3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
      run_op("REM 5/0",    3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
      run_op("DIV ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      run_op("REM ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = rand_operand();
         b  = rand_operand();
         run_op($sformatf("rand%0d f3=%0d a=%0h b=%0h", i, f3, a, b), f3, a, b, model(f3, a, b), 1'b1);
      end

      // Flush on the 10th CALC cycle, then restart on the very next cycle.
      start = 1'b1; func3 = 3'd5; op1 = 32'd1000; op2 = 32'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush calc busy", 64'(busy), 64'(0));
      check("flush calc done", 64'(done), 64'(0));
      check("flush calc result", 64'(result), 64'(exp_last));
      run_op("after flush MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);

      // Flush while in FIN of an early-exit op.
      start = 1'b1; func3 = 3'd5; op1 = 32'd5; op2 = 32'd0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush fin busy", 64'(busy), 64'(0));
      check("flush fin done", 64'(done), 64'(0));
      check("flush fin result", 64'(result), 64'(exp_last));

      // START together with FLUSH in IDLE is dropped.
      start = 1'b1; flush = 1'b1; func3 = 3'd0; op1 = 32'd3; op2 = 32'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("start+flush busy", 64'(busy), 64'(0));
      @(negedge clk);
      check("start+flush done", 64'(done), 64'(0));

      // Reset mid-CALC clears everything.
      start = 1'b1; func3 = 3'd5; op1 = 32'd1000; op2 = 32'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid reset busy", 64'(busy), 64'(0));
      check("mid reset done", 64'(done), 64'(0));
      check("mid reset result", 64'(result), 64'(0));
      reset = 1'b0;
      @(negedge clk);
      run_op("after reset REMU", 3'd7, 32'd1000, 32'd3, 32'd1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
